// File: rtl/d_interp.sv
// -----------------------------------------------------------------------------
// d_interp -- point-by-point comparison interpolator (line / circular arc)
//
// Generates unit step pulses on X+/X-/Y+/Y- that walk the tool from its
// current point to a programmed end point, one step every STEP_DIV cycles.
//
// Build option:
//   D_INTERP_ABORT_EN  adds the 'abort' input; abort during STEP or GAP ends
//                      the move early (draw_overH + err, position held).
//
// Ports:
//   pulse_clk          clock
//   sys_rst_l          asynchronous active-low reset
//   start              command strobe, honoured only when idle
//   mode[1:0]          00 line, 01 arc CW, 10 arc CCW, 11 reserved (error)
//   Xs, Ys             arc start point relative to centre (unused for lines)
//   Xe, Ye             end point (line: from start, arc: from centre)
//   abort              (D_INTERP_ABORT_EN only) cancel the running move
//   X_acc/X_dec        x+ / x- step pulse
//   Y_acc/Y_dec        y+ / y- step pulse
//   busy               high from INIT through OVER
//   draw_overH         one-cycle completion pulse
//   err                one-cycle failure flag, coincident with draw_overH
//   pos_x, pos_y       current position (line: from origin, arc: from centre)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; command words captured on the start edge
// INIT  | load position/accumulators, reject empty or invalid moves
// STEP  | emit one pulse, advance position and accumulator
// GAP   | pulse spacing timer (STEP_DIV-1 cycles), then finish test
// OVER  | draw_overH (and err on failure) for one cycle
// -----------------------------------------------------------------------------
module d_interp #(
  parameter int W         = 16,
  parameter int STEP_DIV  = 2,
  parameter int MAX_STEPS = 65535
) (
  input  logic         pulse_clk,
  input  logic         sys_rst_l,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] Xs,
  input  logic [W-1:0] Ys,
  input  logic [W-1:0] Xe,
  input  logic [W-1:0] Ye,
`ifdef D_INTERP_ABORT_EN
  input  logic         abort,
`endif
  output logic         X_acc,
  output logic         X_dec,
  output logic         Y_acc,
  output logic         Y_dec,
  output logic         busy,
  output logic         draw_overH,
  output logic         err,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam logic [1:0] MODE_LINE = 2'b00;
  localparam logic [1:0] MODE_CCW  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam int EW  = W + 2;
  localparam int FW  = 2 * W + 2;
  localparam int SCW = $clog2(MAX_STEPS + 1);
  // one down-counter serves both as line step count and arc step budget
  localparam int CW  = (SCW > W + 1) ? SCW : W + 1;
  localparam int GW  = (STEP_DIV > 2) ? $clog2(STEP_DIV - 1) : 1;

  localparam logic [GW-1:0] GAP_LOAD  = GW'(STEP_DIV - 2);
  localparam logic [CW-1:0] ARC_LIMIT = CW'(MAX_STEPS);

  function automatic logic [W:0] abs_w(input logic [W-1:0] v);
    logic signed [W:0] e;
    e = $signed({v[W-1], v});
    return e[W] ? $unsigned(-e) : $unsigned(e);
  endfunction

  logic [2:0]           state;
  logic [1:0]           mode_q;
  logic [W-1:0]         xs_q, ys_q, xe_q, ye_q;
  logic [W:0]           axe_q, aye_q;
  logic signed [EW-1:0] e_acc;
  logic signed [FW-1:0] f_acc;
  logic [CW-1:0]        cnt;
  logic [GW-1:0]        gap_cnt;

  logic abort_req;
`ifdef D_INTERP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  logic signed [W-1:0]  cx, cy;
  logic signed [FW-1:0] x_ext, y_ext, f_delta;
  logic [W+1:0]         line_len;
  logic                 step_x, step_up, f_neg, arrive;

  assign cx       = $signed(pos_x);
  assign cy       = $signed(pos_y);
  assign x_ext    = FW'(cx);
  assign y_ext    = FW'(cy);
  assign f_neg    = f_acc[FW-1];
  assign line_len = {1'b0, axe_q} + {1'b0, aye_q};
  assign arrive   = (pos_x == xe_q) && (pos_y == ye_q);

  // step_x selects the axis, step_up the direction of the next pulse
  always_comb begin
    step_x  = 1'b0;
    step_up = 1'b0;
    if (mode_q == MODE_LINE) begin
      if (!e_acc[EW-1] && (axe_q != '0)) begin
        step_x  = 1'b1;
        step_up = ~xe_q[W-1];
      end else begin
        step_x  = 1'b0;
        step_up = ~ye_q[W-1];
      end
    end else if (mode_q == MODE_CCW) begin
      if (cx > 0 && cy >= 0) begin
        step_x  = ~f_neg;
        step_up = f_neg;
      end else if (cx <= 0 && cy > 0) begin
        step_x  = f_neg;
        step_up = 1'b0;
      end else if (cx < 0 && cy <= 0) begin
        step_x  = ~f_neg;
        step_up = ~f_neg;
      end else begin
        step_x  = f_neg;
        step_up = 1'b1;
      end
    end else begin
      if (cx >= 0 && cy > 0) begin
        step_x  = f_neg;
        step_up = f_neg;
      end else if (cx > 0 && cy <= 0) begin
        step_x  = ~f_neg;
        step_up = 1'b0;
      end else if (cx <= 0 && cy < 0) begin
        step_x  = f_neg;
        step_up = ~f_neg;
      end else begin
        step_x  = ~f_neg;
        step_up = 1'b1;
      end
    end
  end

  // F tracks x^2 + y^2 - r^2 incrementally from the pre-step coordinate
  always_comb begin
    f_delta = '0;
    if (step_x)
      f_delta = step_up ? (x_ext <<< 1) + FW'(1) : FW'(1) - (x_ext <<< 1);
    else
      f_delta = step_up ? (y_ext <<< 1) + FW'(1) : FW'(1) - (y_ext <<< 1);
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      axe_q      <= '0;
      aye_q      <= '0;
      e_acc      <= '0;
      f_acc      <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      X_acc      <= 1'b0;
      X_dec      <= 1'b0;
      Y_acc      <= 1'b0;
      Y_dec      <= 1'b0;
      busy       <= 1'b0;
      draw_overH <= 1'b0;
      err        <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
    end else begin
      X_acc      <= 1'b0;
      X_dec      <= 1'b0;
      Y_acc      <= 1'b0;
      Y_dec      <= 1'b0;
      draw_overH <= 1'b0;
      err        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            // captured on the start edge so the decoder may move on
            mode_q <= mode;
            xs_q   <= Xs;
            ys_q   <= Ys;
            xe_q   <= Xe;
            ye_q   <= Ye;
            axe_q  <= abs_w(Xe);
            aye_q  <= abs_w(Ye);
            busy   <= 1'b1;
            state  <= S_INIT;
          end
        end

        S_INIT: begin
          e_acc   <= '0;
          f_acc   <= '0;
          gap_cnt <= '0;
          if (mode_q == MODE_LINE) begin
            pos_x <= '0;
            pos_y <= '0;
            cnt   <= CW'(line_len);
            if (line_len == '0) begin
              draw_overH <= 1'b1;
              state      <= S_OVER;
            end else begin
              state <= S_STEP;
            end
          end else if (mode_q == MODE_RSVD) begin
            draw_overH <= 1'b1;
            err        <= 1'b1;
            state      <= S_OVER;
          end else begin
            pos_x <= xs_q;
            pos_y <= ys_q;
            cnt   <= ARC_LIMIT;
            if (xs_q == '0 && ys_q == '0) begin
              draw_overH <= 1'b1;
              err        <= 1'b1;
              state      <= S_OVER;
            end else if (xs_q == xe_q && ys_q == ye_q) begin
              draw_overH <= 1'b1;
              state      <= S_OVER;
            end else begin
              state <= S_STEP;
            end
          end
        end

        S_STEP: begin
          if (abort_req) begin
            draw_overH <= 1'b1;
            err        <= 1'b1;
            state      <= S_OVER;
          end else begin
            X_acc <= step_x & step_up;
            X_dec <= step_x & ~step_up;
            Y_acc <= ~step_x & step_up;
            Y_dec <= ~step_x & ~step_up;
            if (step_x)
              pos_x <= step_up ? pos_x + W'(1) : pos_x - W'(1);
            else
              pos_y <= step_up ? pos_y + W'(1) : pos_y - W'(1);
            if (mode_q == MODE_LINE)
              e_acc <= step_x ? e_acc - $signed({1'b0, aye_q})
                              : e_acc + $signed({1'b0, axe_q});
            else
              f_acc <= f_acc + f_delta;
            cnt     <= cnt - CW'(1);
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (abort_req) begin
            draw_overH <= 1'b1;
            err        <= 1'b1;
            state      <= S_OVER;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (mode_q == MODE_LINE) begin
            if (cnt == '0) begin
              draw_overH <= 1'b1;
              state      <= S_OVER;
            end else begin
              state <= S_STEP;
            end
          end else if (arrive) begin
            draw_overH <= 1'b1;
            state      <= S_OVER;
          end else if (cnt == '0) begin
            // step budget exhausted without reaching the end point
            draw_overH <= 1'b1;
            err        <= 1'b1;
            state      <= S_OVER;
          end else begin
            state <= S_STEP;
          end
        end

        S_OVER: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_interp.sv
`timescale 1ns/1ps
module tb_d_interp;
  localparam int W    = 16;
  localparam int DIV0 = 2;
  localparam int DIV1 = 3;
  localparam int LIM0 = 65535;
  localparam int LIM1 = 4;

  logic         pulse_clk = 1'b0;
  logic         sys_rst_l = 1'b0;
  logic         start     = 1'b0;
  logic [1:0]   mode      = 2'b00;
  logic [W-1:0] Xs = '0, Ys = '0, Xe = '0, Ye = '0;
`ifdef D_INTERP_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         xa[2], xd[2], ya[2], yd[2], bsy[2], dov[2], erro[2];
  logic [W-1:0] px[2], py[2];

  d_interp #(.W(W), .STEP_DIV(DIV0), .MAX_STEPS(LIM0)) dut (
    .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .start(start), .mode(mode),
    .Xs(Xs), .Ys(Ys), .Xe(Xe), .Ye(Ye),
`ifdef D_INTERP_ABORT_EN
    .abort(abort),
`endif
    .X_acc(xa[0]), .X_dec(xd[0]), .Y_acc(ya[0]), .Y_dec(yd[0]),
    .busy(bsy[0]), .draw_overH(dov[0]), .err(erro[0]),
    .pos_x(px[0]), .pos_y(py[0]));

  d_interp #(.W(W), .STEP_DIV(DIV1), .MAX_STEPS(LIM1)) dut_lim (
    .pulse_clk(pulse_clk), .sys_rst_l(sys_rst_l), .start(start), .mode(mode),
    .Xs(Xs), .Ys(Ys), .Xe(Xe), .Ye(Ye),
`ifdef D_INTERP_ABORT_EN
    .abort(abort),
`endif
    .X_acc(xa[1]), .X_dec(xd[1]), .Y_acc(ya[1]), .Y_dec(yd[1]),
    .busy(bsy[1]), .draw_overH(dov[1]), .err(erro[1]),
    .pos_x(px[1]), .pos_y(py[1]));

  always #5 pulse_clk = ~pulse_clk;

  int cyc = 0;
  always @(posedge pulse_clk) cyc <= cyc + 1;

  typedef struct { int code; int cyc; int x; int y; } pulse_t;  // code 0 X+,1 X-,2 Y+,3 Y-

  pulse_t got_q[2][$];
  pulse_t exp_q[2][$];
  int dcnt[2], done_cyc[2], err_done[2], busy_done[2], busy_after[2], multi[2], stray[2];
  int exp_err[2], exp_fx[2], exp_fy[2];
  int n_chk = 0, n_err = 0;
  int tp53[8] = '{0, 2, 0, 2, 0, 0, 2, 0};

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge pulse_clk) begin
    for (int d = 0; d < 2; d++) begin
      int nh;
      pulse_t p;
      nh = int'(xa[d]) + int'(xd[d]) + int'(ya[d]) + int'(yd[d]);
      if (nh > 1) multi[d]++;
      if (nh == 1) begin
        p.code = xa[d] ? 0 : xd[d] ? 1 : ya[d] ? 2 : 3;
        p.cyc  = cyc;
        p.x    = int'($signed(px[d]));
        p.y    = int'($signed(py[d]));
        got_q[d].push_back(p);
      end
      if (erro[d] && !dov[d]) stray[d]++;
      if (dov[d]) begin
        dcnt[d]++;
        done_cyc[d]  = cyc;
        err_done[d]  = int'(erro[d]);
        busy_done[d] = int'(bsy[d]);
      end
      if (dcnt[d] > 0 && cyc == done_cyc[d] + 1) busy_after[d] = int'(bsy[d]);
    end
  end

  function automatic int div_of(input int d);
    return (d == 0) ? DIV0 : DIV1;
  endfunction

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      got_q[d].delete();
      dcnt[d] = 0; done_cyc[d] = 0; err_done[d] = -1; busy_done[d] = -1;
      busy_after[d] = -1; multi[d] = 0; stray[d] = 0;
    end
  endtask

  // Reference: line by the error-sign rule, arc by F = x^2+y^2-r^2 evaluated directly
  task automatic model(input int d, input int lim, input logic [1:0] md,
                       input int xs, input int ys, input int xe, input int ye);
    int x, y, e, ax, ay, n, r2, f, dx, dy;
    pulse_t p;
    exp_q[d].delete();
    exp_err[d] = 0;
    p.cyc = 0;
    if (md == 2'b00) begin
      ax = (xe < 0) ? -xe : xe;
      ay = (ye < 0) ? -ye : ye;
      x = 0; y = 0; e = 0;
      for (int i = 0; i < ax + ay; i++) begin
        if (e >= 0 && ax != 0) begin
          x += (xe > 0) ? 1 : -1; e -= ay; p.code = (xe > 0) ? 0 : 1;
        end else begin
          y += (ye > 0) ? 1 : -1; e += ax; p.code = (ye > 0) ? 2 : 3;
        end
        p.x = x; p.y = y;
        exp_q[d].push_back(p);
      end
      exp_fx[d] = x; exp_fy[d] = y;
    end else if (md == 2'b11) begin
      exp_err[d] = 1;
    end else if (xs == 0 && ys == 0) begin
      exp_err[d] = 1;
      exp_fx[d] = 0; exp_fy[d] = 0;
    end else begin
      x = xs; y = ys; n = 0;
      r2 = xs * xs + ys * ys;
      while (!(x == xe && y == ye) && n < lim) begin
        f = x * x + y * y - r2;
        dx = 0; dy = 0;
        if (md == 2'b10) begin
          if (x > 0 && y >= 0)       begin if (f >= 0) dx = -1; else dy = 1;  end
          else if (x <= 0 && y > 0)  begin if (f >= 0) dy = -1; else dx = -1; end
          else if (x < 0 && y <= 0)  begin if (f >= 0) dx = 1;  else dy = -1; end
          else                       begin if (f >= 0) dy = 1;  else dx = 1;  end
        end else begin
          if (x >= 0 && y > 0)       begin if (f >= 0) dy = -1; else dx = 1;  end
          else if (x > 0 && y <= 0)  begin if (f >= 0) dx = -1; else dy = -1; end
          else if (x <= 0 && y < 0)  begin if (f >= 0) dy = 1;  else dx = -1; end
          else                       begin if (f >= 0) dx = 1;  else dy = 1;  end
        end
        x += dx; y += dy; n++;
        p.code = (dx > 0) ? 0 : (dx < 0) ? 1 : (dy > 0) ? 2 : 3;
        p.x = x; p.y = y;
        exp_q[d].push_back(p);
      end
      if (!(x == xe && y == ye)) exp_err[d] = 1;
      exp_fx[d] = x; exp_fy[d] = y;
    end
  endtask

  task automatic check_move(input int s, input bit chkpos);
    for (int d = 0; d < 2; d++) begin
      int bad, badt, n;
      bad = 0; badt = 0;
      n = exp_q[d].size();
      chk($sformatf("pulse_count[%0d]", d), got_q[d].size(), n);
      for (int i = 0; i < n && i < got_q[d].size(); i++) begin
        if (got_q[d][i].code != exp_q[d][i].code || got_q[d][i].x != exp_q[d][i].x ||
            got_q[d][i].y != exp_q[d][i].y) bad++;
        if (got_q[d][i].cyc != s + 2 + i * div_of(d)) badt++;
      end
      chk($sformatf("path[%0d]", d), bad, 0);
      chk($sformatf("cadence[%0d]", d), badt, 0);
      chk($sformatf("done_latency[%0d]", d), done_cyc[d] - s, 1 + n * div_of(d));
      chk($sformatf("err[%0d]", d), err_done[d], exp_err[d]);
      chk($sformatf("draw_count[%0d]", d), dcnt[d], 1);
      chk($sformatf("busy_at_done[%0d]", d), busy_done[d], 1);
      chk($sformatf("busy_fall[%0d]", d), busy_after[d], 0);
      chk($sformatf("onehot[%0d]", d), multi[d], 0);
      chk($sformatf("err_stray[%0d]", d), stray[d], 0);
      if (chkpos) begin
        chk($sformatf("final_x[%0d]", d), int'($signed(px[d])), exp_fx[d]);
        chk($sformatf("final_y[%0d]", d), int'($signed(py[d])), exp_fy[d]);
      end
    end
  endtask

  task automatic run_move(input logic [1:0] md, input int xs, input int ys,
                          input int xe, input int ye, input bit poke);
    int s, waitc;
    model(0, LIM0, md, xs, ys, xe, ye);
    model(1, LIM1, md, xs, ys, xe, ye);
    clear_mon();
    @(negedge pulse_clk);
    mode = md; Xs = W'(xs); Ys = W'(ys); Xe = W'(xe); Ye = W'(ye);
    start = 1'b1;
    @(negedge pulse_clk);
    start = 1'b0;
    s = cyc;
    if (poke) begin
      repeat (3) @(negedge pulse_clk);
      mode = 2'b00; Xe = W'(1); Ye = W'(0); start = 1'b1;
      @(negedge pulse_clk);
      start = 1'b0;
    end
    waitc = 0;
    while ((dcnt[0] == 0 || dcnt[1] == 0) && waitc < 3000) begin
      @(negedge pulse_clk);
      waitc++;
    end
    chk("finish_in_time", int'(dcnt[0] > 0 && dcnt[1] > 0), 1);
    repeat (6) @(negedge pulse_clk);
    check_move(s, md != 2'b11);
  endtask

  task automatic axis_pt(input int r, input int k, output int x, output int y);
    x = (k == 0) ? r : (k == 2) ? -r : 0;
    y = (k == 1) ? r : (k == 3) ? -r : 0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs, ys, xe, ye, r, k0, k1, bad, s, waitc;
    logic [1:0] md;

    repeat (3) @(negedge pulse_clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_pulses[%0d]", d), int'(xa[d] | xd[d] | ya[d] | yd[d]), 0);
      chk($sformatf("rst_flags[%0d]", d), int'(bsy[d] | dov[d] | erro[d]), 0);
      chk($sformatf("rst_pos[%0d]", d), int'(px[d] | py[d]), 0);
    end
    sys_rst_l = 1'b1;
    repeat (2) @(negedge pulse_clk);

    run_move(2'b00, 0, 0, 5, 3, 1'b0);
    bad = (got_q[0].size() == 8) ? 0 : 1;
    for (int i = 0; i < 8 && i < got_q[0].size(); i++)
      if (got_q[0][i].code != tp53[i]) bad++;
    chk("line53_order", bad, 0);

    run_move(2'b00, 0, 0, 0, -4, 1'b0);
    run_move(2'b00, 0, 0, 0, 0, 1'b0);

    run_move(2'b10, 5, 0, 0, 5, 1'b0);
    chk("ccw_len", got_q[0].size(), 10);
    chk("ccw_first", (got_q[0].size() > 0) ? got_q[0][0].code : -1, 1);
    chk("lim_len", got_q[1].size(), 4);

    run_move(2'b01, 0, 5, 5, 0, 1'b0);
    bad = 0;
    foreach (got_q[0][i]) if (got_q[0][i].code != 0 && got_q[0][i].code != 3) bad++;
    chk("cw_dirs", bad, 0);

    run_move(2'b11, 3, 4, 1, 2, 1'b0);
    run_move(2'b00, 0, 0, 7, 2, 1'b1);

    for (int t = 0; t < 30; t++) begin
      md = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) md = 2'b11;
      if (md == 2'b00) begin
        xs = 0; ys = 0;
        xe = int'($urandom_range(0, 30)) - 15;
        ye = int'($urandom_range(0, 30)) - 15;
      end else begin
        r  = int'($urandom_range(2, 12));
        k0 = int'($urandom_range(0, 3));
        k1 = (k0 + int'($urandom_range(1, 3))) % 4;
        if ($urandom_range(0, 7) == 0) k1 = k0;
        axis_pt(r, k0, xs, ys);
        axis_pt(r, k1, xe, ye);
        if ($urandom_range(0, 9) == 0) begin xs = 0; ys = 0; end
      end
      run_move(md, xs, ys, xe, ye, 1'b0);
    end

    // asynchronous reset in the middle of a line move
    clear_mon();
    @(negedge pulse_clk);
    mode = 2'b00; Xe = W'(6); Ye = W'(6); start = 1'b1;
    @(negedge pulse_clk);
    start = 1'b0;
    waitc = 0;
    while (got_q[0].size() < 3 && waitc < 200) begin
      @(negedge pulse_clk);
      waitc++;
    end
    #2 sys_rst_l = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_pulses[%0d]", d), int'(xa[d] | xd[d] | ya[d] | yd[d] | bsy[d] | dov[d] | erro[d]), 0);
      chk($sformatf("midrst_pos[%0d]", d), int'(px[d] | py[d]), 0);
    end
    repeat (4) @(negedge pulse_clk);
    chk("midrst_quiet", got_q[0].size(), 3);
    sys_rst_l = 1'b1;
    repeat (2) @(negedge pulse_clk);

`ifdef D_INTERP_ABORT_EN
    clear_mon();
    @(negedge pulse_clk);
    mode = 2'b00; Xe = W'(8); Ye = W'(0); start = 1'b1;
    @(negedge pulse_clk);
    start = 1'b0;
    s = cyc;
    waitc = 0;
    while (got_q[0].size() < 3 && waitc < 200) begin
      @(negedge pulse_clk);
      waitc++;
    end
    abort = 1'b1;
    @(negedge pulse_clk);
    abort = 1'b0;
    waitc = 0;
    while ((dcnt[0] == 0 || dcnt[1] == 0) && waitc < 200) begin
      @(negedge pulse_clk);
      waitc++;
    end
    repeat (6) @(negedge pulse_clk);
    chk("abort_pulses", got_q[0].size(), 3);
    chk("abort_done", done_cyc[0] - s, 7);
    chk("abort_err", err_done[0], 1);
    chk("abort_pos", int'($signed(px[0])), 3);
    chk("abort_pulses_lim", got_q[1].size(), 2);
    chk("abort_err_lim", err_done[1], 1);
    chk("abort_pos_lim", int'($signed(px[1])), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
